// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU function codes, FSM state encoding
// and perf counter helpers (counters only exist when ALU_ARB_PERF_EN is defined).
package alu_share_arbiter_pkg;

  localparam int unsigned ALU_FN_LEN   = 4;
  localparam int unsigned PERF_CNT_LEN = 16;

  localparam logic [ALU_FN_LEN-1:0] ALU_ADD = 4'h0;
  localparam logic [ALU_FN_LEN-1:0] ALU_SUB = 4'h1;
  localparam logic [ALU_FN_LEN-1:0] ALU_AND = 4'h2;
  localparam logic [ALU_FN_LEN-1:0] ALU_OR  = 4'h3;
  localparam logic [ALU_FN_LEN-1:0] ALU_XOR = 4'h4;
  localparam logic [ALU_FN_LEN-1:0] ALU_X   = 4'hF;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  // Saturating increment, sticks at all-ones.
  function automatic logic [PERF_CNT_LEN-1:0] sat_inc(input logic [PERF_CNT_LEN-1:0] v);
    return (v == {PERF_CNT_LEN{1'b1}}) ? v : v + PERF_CNT_LEN'(1);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches the request vector starting one past last_g.
module alu_share_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_g_i,
  output logic [NUM_REQ-1:0] gnt_oh_c_o,
  output logic [IDX_W-1:0]   gnt_idx_c_o,
  output logic               gnt_any_c_o
);

  int unsigned idx;

  always_comb begin
    gnt_oh_c_o  = '0;
    gnt_idx_c_o = '0;
    gnt_any_c_o = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_g_i) + k) % NUM_REQ;
      if (!gnt_any_c_o && req_i[IDX_W'(idx)]) begin
        gnt_any_c_o               = 1'b1;
        gnt_idx_c_o               = IDX_W'(idx);
        gnt_oh_c_o[IDX_W'(idx)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NUM_REQ requesters with a one-entry result buffer.
// Optional macro ALU_ARB_PERF_EN adds saturating grant/conflict perf counters.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned FN_LEN   = ALU_FN_LEN,
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned TAG_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FN_LEN-1:0]   req_fn,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_src1,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_src2,
  input  logic [NUM_REQ*TAG_LEN-1:0]  req_tag,
  output logic [FN_LEN-1:0]           alu_fn,
  output logic [DATA_LEN-1:0]         alu_src1,
  output logic [DATA_LEN-1:0]         alu_src2,
  input  logic [DATA_LEN-1:0]         alu_out,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [DATA_LEN-1:0]         rsp_data,
  output logic [TAG_LEN-1:0]          rsp_tag
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_LEN-1:0] perf_grant_cnt,
  output logic [PERF_CNT_LEN-1:0]         perf_conflict_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_LEN-1:0]  rsp_tag_q, rsp_tag_d;
  logic [IDX_W-1:0]    rsp_id_q, rsp_id_d;
  logic [IDX_W-1:0]    last_g_q, last_g_d;

  logic                slot_open_c;
  logic [NUM_REQ-1:0]  arb_req_c;
  logic [NUM_REQ-1:0]  gnt_oh_c;
  logic [IDX_W-1:0]    gnt_idx_c;
  logic                gnt_any_c;
  logic [TAG_LEN-1:0]  gnt_tag_c;

  // The slot opens when the buffer is empty or its owner drains it this cycle.
  assign slot_open_c = (state_q == ARB_IDLE) || rsp_ready[rsp_id_q];
  assign arb_req_c   = slot_open_c ? req_valid : '0;

  alu_share_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req_i      (arb_req_c),
    .last_g_i   (last_g_q),
    .gnt_oh_c_o (gnt_oh_c),
    .gnt_idx_c_o(gnt_idx_c),
    .gnt_any_c_o(gnt_any_c)
  );

  assign req_ready = gnt_oh_c;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;

  always_comb begin
    alu_fn    = FN_LEN'(ALU_X);
    alu_src1  = '0;
    alu_src2  = '0;
    gnt_tag_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh_c[i]) begin
        alu_fn    = req_fn[i*FN_LEN +: FN_LEN];
        alu_src1  = req_src1[i*DATA_LEN +: DATA_LEN];
        alu_src2  = req_src2[i*DATA_LEN +: DATA_LEN];
        gnt_tag_c = req_tag[i*TAG_LEN +: TAG_LEN];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == ARB_HOLD) && (rsp_id_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_id_d   = rsp_id_q;
    last_g_d   = last_g_q;
    case (state_q)
      ARB_IDLE: if (gnt_any_c) state_d = ARB_HOLD;
      ARB_HOLD: if (!gnt_any_c && rsp_ready[rsp_id_q]) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    // A grant reloads the buffer even while the previous result drains.
    if (gnt_any_c) begin
      rsp_data_d = alu_out;
      rsp_tag_d  = gnt_tag_c;
      rsp_id_d   = gnt_idx_c;
      last_g_d   = gnt_idx_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_id_q   <= '0;
      last_g_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_id_q   <= rsp_id_d;
      last_g_q   <= last_g_d;
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [PERF_CNT_LEN-1:0] grant_cnt_q [NUM_REQ];
  logic [PERF_CNT_LEN-1:0] grant_cnt_d [NUM_REQ];
  logic [PERF_CNT_LEN-1:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    perf_grant_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = grant_cnt_q[i];
      if (gnt_oh_c[i]) grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
      perf_grant_cnt[i*PERF_CNT_LEN +: PERF_CNT_LEN] = grant_cnt_q[i];
    end
    if (slot_open_c && ($countones(req_valid) > 1)) conflict_cnt_d = sat_inc(conflict_cnt_q);
  end

  assign perf_conflict_cnt = conflict_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
    end
  end
`endif

endmodule
